// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: shared types and constants for the WM8731 configuration sequencer
//   cfg_entry_t  - one codec register write (7-bit register address, 9-bit data)
//   state_t      - sequencer FSM states
//   INIT_TABLE   - power-up register image replayed after every i_start
//   WM8731_ADDR  - codec 7-bit I2C device address
package codec_cfg_pkg;

    localparam logic [6:0] WM8731_ADDR = 7'h1A;
    localparam int         INIT_LEN    = 10;

    typedef struct packed {
        logic [6:0] reg_addr;
        logic [8:0] data;
    } cfg_entry_t;

    // Fixed encodings so state values seen in older dumps keep their meaning.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_INIT_ISSUE = 3'd1,
        S_WAIT       = 3'd2,
        S_GAP        = 3'd3,
        S_READY      = 3'd4,
        S_RT_ISSUE   = 3'd5,
        S_ERROR      = 3'd6
    } state_t;

    localparam cfg_entry_t [0:INIT_LEN-1] INIT_TABLE = '{
        '{7'd0, 9'h097},
        '{7'd1, 9'h097},
        '{7'd2, 9'h079},
        '{7'd3, 9'h079},
        '{7'd4, 9'h015},
        '{7'd5, 9'h000},
        '{7'd6, 9'h000},
        '{7'd7, 9'h042},
        '{7'd8, 9'h019},
        '{7'd9, 9'h001}
    };

endpackage

// File: rtl/codec_cfg_rom.sv
// codec_cfg_rom: combinational lookup of one init-table entry
//   i_idx   - init table index (0..INIT_LEN-1; larger values read as all-zero)
//   o_entry - register address and data for that index
module codec_cfg_rom
    import codec_cfg_pkg::*;
(
    input  logic [3:0] i_idx,
    output cfg_entry_t o_entry
);

    assign o_entry = (i_idx < 4'(INIT_LEN)) ? INIT_TABLE[i_idx] : '0;

endmodule

// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: sequences WM8731 register writes over a shared I2C frame writer
//   i_clk, i_rst_n          - clock, asynchronous active-low reset
//   i_start                 - (re)start the init table replay (honoured in idle/ready/error)
//   o_init_done             - all init frames ACKed
//   i_req_valid/o_req_ready - runtime write handshake, with i_req_reg / i_req_data
//   o_i2c_start/o_i2c_frame - one-cycle launch pulse and the registered 24-bit frame
//   i_i2c_done/i_i2c_nack   - frame-complete pulse and its NACK status
//   o_busy                  - a frame or inter-frame gap is in progress
//   o_error                 - sticky: a frame was NACKed on every allowed attempt
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = WM8731_ADDR,
    parameter int         MAX_RETRY  = 3,
    parameter int         GAP_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic        o_init_done,
    input  logic        i_req_valid,
    input  logic [6:0]  i_req_reg,
    input  logic [8:0]  i_req_data,
    output logic        o_req_ready,
    output logic        o_i2c_start,
    output logic [23:0] o_i2c_frame,
    input  logic        i_i2c_done,
    input  logic        i_i2c_nack,
    output logic        o_busy,
    output logic        o_error
);

    localparam int             RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0]  RMAX = RW'(MAX_RETRY);
    localparam logic [7:0]     GMAX = 8'(GAP_CYCLES - 1);
    localparam logic [3:0]     LAST = 4'(INIT_LEN);

    state_t        state, state_nxt;
    logic [3:0]    idx, idx_nxt;
    logic [RW-1:0] retry, retry_nxt;
    logic [7:0]    gap_cnt, gap_nxt;
    logic          rt, rt_nxt;
    logic [6:0]    rq_reg, rq_reg_nxt;
    logic [8:0]    rq_data, rq_data_nxt;
    logic          done_nxt, err_nxt;
    logic          restart;
    logic [23:0]   frame_nxt;
    cfg_entry_t    rom_entry;

    // The ROM looks up the index the FSM is about to issue, so the frame
    // register can be loaded on the same edge that raises o_i2c_start.
    codec_cfg_rom u_rom (
        .i_idx   (idx_nxt),
        .o_entry (rom_entry)
    );

    assign restart     = i_start && (state inside {S_IDLE, S_READY, S_ERROR});
    assign o_req_ready = (state == S_READY) && !i_start;
    assign o_busy      = !(state inside {S_IDLE, S_READY, S_ERROR});

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        retry_nxt   = retry;
        gap_nxt     = '0;
        rt_nxt      = rt;
        rq_reg_nxt  = rq_reg;
        rq_data_nxt = rq_data;
        done_nxt    = o_init_done;
        err_nxt     = o_error;
        if (restart) begin
            state_nxt = S_INIT_ISSUE;
            idx_nxt   = '0;
            retry_nxt = '0;
            rt_nxt    = 1'b0;
            done_nxt  = 1'b0;
            err_nxt   = 1'b0;
        end else begin
            case (state)
                S_INIT_ISSUE, S_RT_ISSUE: state_nxt = S_WAIT;
                S_WAIT: begin
                    if (i_i2c_done) begin
                        if (!i_i2c_nack) begin
                            retry_nxt = '0;
                            idx_nxt   = rt ? idx : idx + 4'd1;
                            state_nxt = S_GAP;
                        end else if (retry != RMAX) begin
                            retry_nxt = retry + RW'(1);
                            state_nxt = S_GAP;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = S_ERROR;
                        end
                    end
                end
                S_GAP: begin
                    gap_nxt = gap_cnt + 8'd1;
                    // A nonzero retry count at gap expiry means the last frame was
                    // NACKed and must be re-sent from the same source.
                    if (gap_cnt == GMAX) begin
                        gap_nxt   = '0;
                        state_nxt = (retry != '0) ? (rt ? S_RT_ISSUE : S_INIT_ISSUE) :
                                    (!rt && idx != LAST) ? S_INIT_ISSUE : S_READY;
                        done_nxt  = o_init_done || (retry == '0 && !rt && idx == LAST);
                    end
                end
                S_READY: begin
                    if (i_req_valid) begin
                        rq_reg_nxt  = i_req_reg;
                        rq_data_nxt = i_req_data;
                        retry_nxt   = '0;
                        rt_nxt      = 1'b1;
                        state_nxt   = S_RT_ISSUE;
                    end
                end
                S_IDLE, S_ERROR: state_nxt = state;
                default:         state_nxt = S_IDLE;
            endcase
        end
    end

    assign frame_nxt = (state_nxt == S_RT_ISSUE)   ? {DEV_ADDR, 1'b0, rq_reg_nxt, rq_data_nxt} :
                       (state_nxt == S_INIT_ISSUE) ? {DEV_ADDR, 1'b0, rom_entry} :
                       o_i2c_frame;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            retry       <= '0;
            gap_cnt     <= '0;
            rt          <= 1'b0;
            rq_reg      <= '0;
            rq_data     <= '0;
            o_init_done <= 1'b0;
            o_error     <= 1'b0;
            o_i2c_start <= 1'b0;
            o_i2c_frame <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            retry       <= retry_nxt;
            gap_cnt     <= gap_nxt;
            rt          <= rt_nxt;
            rq_reg      <= rq_reg_nxt;
            rq_data     <= rq_data_nxt;
            o_init_done <= done_nxt;
            o_error     <= err_nxt;
            o_i2c_start <= (state_nxt == S_INIT_ISSUE) || (state_nxt == S_RT_ISSUE);
            o_i2c_frame <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// tb_codec_cfg_sequencer: scoreboard bench with an I2C writer model for codec_cfg_sequencer
module tb_codec_cfg_sequencer;

    localparam int GAP  = 16;
    localparam int MAXR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        req_valid = 1'b0;
    logic [6:0]  req_reg = '0;
    logic [8:0]  req_data = '0;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        init_done, req_ready, i2c_start, busy, error;
    logic [23:0] i2c_frame;

    typedef struct {
        logic [23:0] frame;
        bit          chk_gap;
    } exp_t;

    exp_t        exp_q[$];
    bit          nack_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 50;
    int          nstarts = 0;
    int          target = 0;
    int          nk[10];
    logic [23:0] seen_last = '0;
    logic [8:0]  init_val[10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h015,
                                  9'h000, 9'h000, 9'h042, 9'h019, 9'h001};

    codec_cfg_sequencer #(
        .DEV_ADDR   (7'h1A),
        .MAX_RETRY  (MAXR),
        .GAP_CYCLES (GAP)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .o_init_done (init_done),
        .i_req_valid (req_valid),
        .i_req_reg   (req_reg),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_i2c_start (i2c_start),
        .o_i2c_frame (i2c_frame),
        .i_i2c_done  (i2c_done),
        .i_i2c_nack  (i2c_nack),
        .o_busy      (busy),
        .o_error     (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic logic [23:0] fr(input logic [6:0] r, input logic [8:0] d);
        return {7'h1A, 1'b0, r, d};
    endfunction

    // Reference model of one register write: a frame is attempted until it is
    // ACKed or MAX_RETRY+1 attempts have been NACKed.
    task automatic push_write(input logic [6:0] r, input logic [8:0] d, input int n,
                              input bit first_gap, output bit ok);
        exp_t e;
        int   tries;
        tries = (n > MAXR) ? MAXR + 1 : n + 1;
        for (int t = 0; t < tries; t++) begin
            e.frame   = fr(r, d);
            e.chk_gap = (t > 0) || first_gap;
            exp_q.push_back(e);
            nack_q.push_back(t < n);
        end
        ok = (n <= MAXR);
    endtask

    task automatic push_init(input int upto);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < upto && ok; i++) push_write(7'(i), init_val[i], nk[i], i > 0, ok);
    endtask

    function automatic bit cond(input int w);
        case (w)
            0:       return init_done && !busy;
            1:       return error;
            2:       return req_ready;
            default: return nstarts >= target;
        endcase
    endfunction

    task automatic wait_cond(input int w, input string name);
        int n;
        n = 0;
        while (!cond(w) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_reached"}, 32'(cond(w)), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_req(input logic [6:0] r, input logic [8:0] d, input int n);
        bit ok;
        wait_cond(2, "req_ready");
        req_valid = 1'b1;
        req_reg   = r;
        req_data  = d;
        push_write(r, d, n, 1'b0, ok);
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_drop", 32'(req_ready), 32'd0);
        wait_cond(2, "req_complete");
        chk("req_last_frame", 32'(seen_last), 32'(fr(r, d)));
    endtask

    // Writer model: answers each start pulse with done after `lat` cycles,
    // NACKing according to the scoreboard's schedule; reset aborts the frame.
    initial begin
        bit abort, nb;
        forever begin
            @(negedge clk);
            if (i2c_start) begin
                abort = 1'b0;
                nb    = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                for (int i = 0; i < lat && !abort; i++) begin
                    @(posedge clk);
                    abort = !rst_n;
                end
                if (!abort) begin
                    #1;
                    i2c_done = 1'b1;
                    i2c_nack = nb;
                    @(posedge clk);
                    #1;
                    i2c_done = 1'b0;
                    i2c_nack = 1'b0;
                end
            end
        end
    end

    // Monitor: every start pulse must match the next expected frame and,
    // after a completed frame, follow it by exactly lat + GAP + 1 cycles.
    initial begin
        int   last;
        exp_t e;
        last = 0;
        forever begin
            @(negedge clk);
            if (i2c_start) begin
                nstarts++;
                seen_last = i2c_frame;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got frame %h, expected no frame", i2c_frame);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame", 32'(i2c_frame), 32'(e.frame));
                    if (e.chk_gap) chk("start_spacing", 32'(cyc - last), 32'(lat + GAP + 1));
                end
                last = cyc;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        foreach (nk[i]) nk[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_i2c_start", 32'(i2c_start), 32'd0);
        chk("rst_frame", 32'(i2c_frame), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean init sequence, writer ACKs after 50 cycles.
        lat = 50;
        push_init(10);
        pulse_start();
        chk("init1_busy", 32'(busy), 32'd1);
        wait_cond(0, "init1");
        chk("init1_last_frame", 32'(seen_last), 32'h341201);
        chk("init1_queue", 32'(exp_q.size()), 32'd0);
        chk("init1_ready", 32'(req_ready), 32'd1);

        // Third frame NACKed twice, then ACKed.
        lat = $urandom_range(5, 40);
        nk[2] = 2;
        push_init(10);
        pulse_start();
        chk("nack_done_cleared", 32'(init_done), 32'd0);
        wait_cond(0, "nack2");
        chk("nack2_error", 32'(error), 32'd0);
        nk[2] = 0;

        // First frame NACKed on every attempt.
        lat = $urandom_range(5, 40);
        nk[0] = MAXR + 1;
        base = nstarts;
        push_init(10);
        pulse_start();
        wait_cond(1, "error");
        req_valid = 1'b1;
        req_reg   = 7'h05;
        req_data  = 9'h1AA;
        repeat (40) @(negedge clk);
        chk("err_starts", 32'(nstarts - base), 32'(MAXR + 1));
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_req_ready", 32'(req_ready), 32'd0);
        chk("err_init_done", 32'(init_done), 32'd0);
        req_valid = 1'b0;
        nk[0] = 0;
        push_init(10);
        pulse_start();
        chk("err_cleared", 32'(error), 32'd0);
        wait_cond(0, "err_restart");

        // Runtime writes: the fixed example, then random ones with retries.
        lat = $urandom_range(5, 40);
        do_req(7'h02, 9'h07F, 0);
        for (int k = 0; k < 8; k++)
            do_req(7'($urandom_range(0, 127)), 9'($urandom_range(0, 511)), $urandom_range(0, MAXR));

        // i_start and a request in the same cycle: init wins, request is held.
        lat = $urandom_range(5, 40);
        wait_cond(2, "collide_ready");
        begin
            bit ok;
            push_init(10);
            push_write(7'h04, 9'h012, 0, 1'b0, ok);
        end
        start     = 1'b1;
        req_valid = 1'b1;
        req_reg   = 7'h04;
        req_data  = 9'h012;
        #1;
        chk("collide_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("collide_done_cleared", 32'(init_done), 32'd0);
        wait_cond(2, "held_accept");
        chk("held_after_init", 32'(init_done), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_cond(2, "held_complete");
        chk("held_frame", 32'(seen_last), 32'h340812);

        // Asynchronous reset while frame 5 is on the bus.
        lat = 50;
        push_init(6);
        target = nstarts + 6;
        pulse_start();
        wait_cond(3, "frame5");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_init_done", 32'(init_done), 32'd0);
        chk("arst_start", 32'(i2c_start), 32'd0);
        chk("arst_frame", 32'(i2c_frame), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_error", 32'(error), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_init(10);
        pulse_start();
        wait_cond(0, "post_reset_init");

        repeat (5) @(negedge clk);
        chk("final_exp_queue", 32'(exp_q.size()), 32'd0);
        chk("final_nack_queue", 32'(nack_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
